nv_nvdla_cacc_abuf_rmw_ctrl: RTL and testbench

- Read-modify-write controller that sits in front of the CACC assembly buffer SRAM wrapper.
- Takes per-stripe partial sums from the MAC side, reads the prior accumulation from the abuf, adds lane-wise and writes the sum back.
- On the final stripe it also emits the result toward delivery.
- Hides the abuf's fixed 2-cycle read latency by forwarding from its own recent writes; credit-based flow control toward the delivery buffer.

---
 rtl/nv_nvdla_cacc_abuf_rmw_ctrl_pkg.sv | 18 +
 rtl/nv_nvdla_cacc_abuf_lane_add.sv | 32 +++
 rtl/nv_nvdla_cacc_abuf_rmw_ctrl.sv | 147 ++++++++++++++
 tb/tb_nv_nvdla_cacc_abuf_rmw_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nv_nvdla_cacc_abuf_rmw_ctrl_pkg.sv
// rtl/nv_nvdla_cacc_abuf_rmw_ctrl_pkg.sv - shared constants and pipeline-stage record for the abuf RMW controller
package nv_nvdla_cacc_abuf_rmw_ctrl_pkg;

  localparam int ABUF_AWIDTH_DEF = 6;
  localparam int LANES_DEF       = 8;
  localparam int ELEM_W_DEF      = 32;
  localparam int ACC_W           = LANES_DEF * ELEM_W_DEF;
  localparam int CREDIT_W        = 8;

  typedef struct packed {
    logic                       valid;
    logic [ABUF_AWIDTH_DEF-1:0] addr;
    logic                       first;
    logic                       last;
    logic [ACC_W-1:0]           data;
  } rmw_stage_t;

endpackage

// File: rtl/nv_nvdla_cacc_abuf_lane_add.sv
// rtl/nv_nvdla_cacc_abuf_lane_add.sv - single-lane signed add; clamps instead of wrapping when NVDLA_CACC_ABUF_SAT_EN is defined
module nv_nvdla_cacc_abuf_lane_add #(
  parameter int ELEM_W = 32
) (
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  output logic [ELEM_W-1:0] sum
`ifdef NVDLA_CACC_ABUF_SAT_EN
  , output logic            sat
`endif
);

`ifdef NVDLA_CACC_ABUF_SAT_EN
  logic [ELEM_W-1:0] raw;
  logic              ovf;

  assign raw = a + b;
  // overflow only when both operands share a sign and the result flips it
  assign ovf = (a[ELEM_W-1] == b[ELEM_W-1]) && (raw[ELEM_W-1] != a[ELEM_W-1]);
  assign sat = ovf;

  always_comb begin
    sum = raw;
    if (ovf) begin
      sum = a[ELEM_W-1] ? {1'b1, {(ELEM_W-1){1'b0}}} : {1'b0, {(ELEM_W-1){1'b1}}};
    end
  end
`else
  assign sum = a + b;
`endif

endmodule

// File: rtl/nv_nvdla_cacc_abuf_rmw_ctrl.sv
// rtl/nv_nvdla_cacc_abuf_rmw_ctrl.sv - CACC abuf read-modify-write controller with write forwarding and delivery credits
// Optional NVDLA_CACC_ABUF_SAT_EN: lane saturation plus sticky sat_flag port.
module nv_nvdla_cacc_abuf_rmw_ctrl
  import nv_nvdla_cacc_abuf_rmw_ctrl_pkg::*;
#(
  parameter int ABUF_AWIDTH = ABUF_AWIDTH_DEF,
  parameter int LANES       = LANES_DEF,
  parameter int ELEM_W      = ELEM_W_DEF,
  parameter int CREDITS     = 16
) (
  input  logic                      nvdla_core_clk,
  input  logic                      nvdla_core_rstn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ABUF_AWIDTH-1:0]    in_addr,
  input  logic [LANES*ELEM_W-1:0]   in_data,
  input  logic                      in_first,
  input  logic                      in_last,
  output logic                      abuf_rd_en,
  output logic [ABUF_AWIDTH-1:0]    abuf_rd_addr,
  input  logic [LANES*ELEM_W-1:0]   abuf_rd_data,
  output logic                      abuf_wr_en,
  output logic [ABUF_AWIDTH-1:0]    abuf_wr_addr,
  output logic [LANES*ELEM_W-1:0]   abuf_wr_data,
  output logic                      out_valid,
  output logic [ABUF_AWIDTH-1:0]    out_addr,
  output logic [LANES*ELEM_W-1:0]   out_data,
  input  logic                      dlv_credit_ret
`ifdef NVDLA_CACC_ABUF_SAT_EN
  , output logic                    sat_flag
`endif
);

  localparam int DW = LANES * ELEM_W;

  logic                   accept;
  rmw_stage_t             stage_in;
  rmw_stage_t             s1;
  rmw_stage_t             s2;
  logic                   w2_valid;
  logic [ABUF_AWIDTH-1:0] w2_addr;
  logic [DW-1:0]          w2_data;
  logic [DW-1:0]          base;
  logic [DW-1:0]          sum;
  logic [CREDIT_W-1:0]    credit_cnt;
  logic                   consume;
  logic                   credit_back;
`ifdef NVDLA_CACC_ABUF_SAT_EN
  logic [LANES-1:0]       lane_sat;
`endif

  assign accept       = in_valid & in_ready;
  assign abuf_rd_en   = accept & ~in_first;
  assign abuf_rd_addr = in_addr;

  always_comb begin
    stage_in       = '0;
    stage_in.valid = accept;
    stage_in.addr  = in_addr;
    stage_in.first = in_first;
    stage_in.last  = in_last;
    stage_in.data  = in_data;
  end

  // Only the valid bits are reset; payload flops just follow the pipe.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      s1.valid <= 1'b0;
      s2.valid <= 1'b0;
    end else begin
      s1 <= stage_in;
      s2 <= s1;
    end
  end

  // abuf_wr_* is the W1 forward register; W2 holds the write one cycle older,
  // whose SRAM write coincides with the array read and so returns stale data.
  always_comb begin
    base = abuf_rd_data;
    if (s2.first) begin
      base = '0;
    end else if (abuf_wr_en && (abuf_wr_addr == s2.addr)) begin
      base = abuf_wr_data;
    end else if (w2_valid && (w2_addr == s2.addr)) begin
      base = w2_data;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    nv_nvdla_cacc_abuf_lane_add #(.ELEM_W(ELEM_W)) u_add (
      .a   (base[i*ELEM_W +: ELEM_W]),
      .b   (s2.data[i*ELEM_W +: ELEM_W]),
      .sum (sum[i*ELEM_W +: ELEM_W])
`ifdef NVDLA_CACC_ABUF_SAT_EN
      , .sat (lane_sat[i])
`endif
    );
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      abuf_wr_en <= 1'b0;
      out_valid  <= 1'b0;
      w2_valid   <= 1'b0;
    end else begin
      abuf_wr_en <= s2.valid;
      out_valid  <= s2.valid & s2.last;
      w2_valid   <= abuf_wr_en;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    abuf_wr_addr <= s2.addr;
    abuf_wr_data <= sum;
    w2_addr      <= abuf_wr_addr;
    w2_data      <= abuf_wr_data;
  end

  assign out_addr = abuf_wr_addr;
  assign out_data = abuf_wr_data;

`ifdef NVDLA_CACC_ABUF_SAT_EN
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      sat_flag <= 1'b0;
    end else if (s2.valid && (|lane_sat)) begin
      sat_flag <= 1'b1;
    end
  end
`endif

  // A return arriving with the pool already full has no matching consume.
  assign in_ready    = (credit_cnt != '0);
  assign consume     = accept & in_last;
  assign credit_back = dlv_credit_ret & (credit_cnt != CREDIT_W'(CREDITS));

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      credit_cnt <= CREDIT_W'(CREDITS);
    end else if (consume && !dlv_credit_ret) begin
      credit_cnt <= credit_cnt - 1'b1;
    end else if (credit_back && !consume) begin
      credit_cnt <= credit_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_nv_nvdla_cacc_abuf_rmw_ctrl.sv
// tb/tb_nv_nvdla_cacc_abuf_rmw_ctrl.sv - directed self-checking bench for the abuf RMW controller
module tb_nv_nvdla_cacc_abuf_rmw_ctrl;

  localparam int AW = 6;
  localparam int DW = 256;

  logic          clk;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          in_first;
  logic          in_last;
  logic          abuf_rd_en;
  logic [AW-1:0] abuf_rd_addr;
  logic [DW-1:0] abuf_rd_data;
  logic          abuf_wr_en;
  logic [AW-1:0] abuf_wr_addr;
  logic [DW-1:0] abuf_wr_data;
  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          dlv_credit_ret;
`ifdef NVDLA_CACC_ABUF_SAT_EN
  logic          sat_flag;
`endif

  int n_checks;
  int n_errors;

  nv_nvdla_cacc_abuf_rmw_ctrl dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_addr         (in_addr),
    .in_data         (in_data),
    .in_first        (in_first),
    .in_last         (in_last),
    .abuf_rd_en      (abuf_rd_en),
    .abuf_rd_addr    (abuf_rd_addr),
    .abuf_rd_data    (abuf_rd_data),
    .abuf_wr_en      (abuf_wr_en),
    .abuf_wr_addr    (abuf_wr_addr),
    .abuf_wr_data    (abuf_wr_data),
    .out_valid       (out_valid),
    .out_addr        (out_addr),
    .out_data        (out_data),
    .dlv_credit_ret  (dlv_credit_ret)
`ifdef NVDLA_CACC_ABUF_SAT_EN
    , .sat_flag      (sat_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // abuf model: address registered, array read one cycle later, writes land at the same edge
  logic [DW-1:0] mem [64];
  logic [AW-1:0] rd_addr_q;
  logic          poison;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
  end

  always @(posedge clk) begin
    rd_addr_q    <= abuf_rd_addr;
    abuf_rd_data <= poison ? {8{32'hDEADBEEF}} : mem[rd_addr_q];
    if (abuf_wr_en) mem[abuf_wr_addr] <= abuf_wr_data;
  end

  logic [DW-1:0] wr_d [$];
  logic [AW-1:0] wr_a [$];
  logic [DW-1:0] out_d [$];
  logic [AW-1:0] out_a [$];

  always @(negedge clk) begin
    if (abuf_wr_en) begin
      wr_d.push_back(abuf_wr_data);
      wr_a.push_back(abuf_wr_addr);
    end
    if (out_valid) begin
      out_d.push_back(out_data);
      out_a.push_back(out_addr);
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic f, input logic l, output logic acc);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_first = f;
    in_last  = l;
    #1;
    acc = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic return_all;
    dlv_credit_ret = 1'b1;
    cycles(20);
    dlv_credit_ret = 1'b0;
  endtask

  logic          acc;
  int            wb;
  int            ob;
  int            n_acc;
  logic [DW-1:0] va;
  logic [DW-1:0] vb;
  logic [DW-1:0] ve;

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rstn           = 1'b0;
    in_valid       = 1'b0;
    in_addr        = '0;
    in_data        = '0;
    in_first       = 1'b0;
    in_last        = 1'b0;
    dlv_credit_ret = 1'b0;
    poison         = 1'b0;
    cycles(3);

    check("rst_wr_en", abuf_wr_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_rd_en", abuf_rd_en, 0);
    check("rst_credit", dut.credit_cnt, 16);
    rstn = 1'b1;
    cycles(1);
    check("rst_in_ready", in_ready, 1);
`ifdef NVDLA_CACC_ABUF_SAT_EN
    check("rst_sat_flag", sat_flag, 0);
`endif

    // single op sequence through the SRAM path
    wb = wr_d.size(); ob = out_d.size();
    send(6'd3, {8{32'd5}}, 1'b1, 1'b0, acc);
    cycles(4);
    send(6'd3, {8{32'd5}}, 1'b0, 1'b0, acc);
    cycles(4);
    send(6'd3, {8{32'd5}}, 1'b0, 1'b1, acc);
    cycles(6);
    check("t1_nwr", wr_d.size() - wb, 3);
    check("t1_wr0", wr_d[wb], {8{32'd5}});
    check("t1_wr1", wr_d[wb+1], {8{32'd10}});
    check("t1_wr2", wr_d[wb+2], {8{32'd15}});
    check("t1_wr_addr", wr_a[wb+2], 3);
    check("t1_nout", out_d.size() - ob, 1);
    check("t1_out_data", out_d[ob], {8{32'd15}});
    check("t1_out_addr", out_a[ob], 3);

    // back-to-back same address, SRAM data poisoned
    poison = 1'b1;
    wb = wr_d.size(); ob = out_d.size();
    send(6'd7, {8{32'd1}}, 1'b1, 1'b0, acc);
    send(6'd7, {8{32'd2}}, 1'b0, 1'b0, acc);
    send(6'd7, {8{32'd3}}, 1'b0, 1'b0, acc);
    send(6'd7, {8{32'd4}}, 1'b0, 1'b1, acc);
    cycles(6);
    check("t2_nwr", wr_d.size() - wb, 4);
    check("t2_wr1", wr_d[wb+1], {8{32'd3}});
    check("t2_wr2", wr_d[wb+2], {8{32'd6}});
    check("t2_nout", out_d.size() - ob, 1);
    check("t2_out_data", out_d[ob], {8{32'd10}});
    check("t2_out_addr", out_a[ob], 7);

    // interleaved A/B: A relies on W2, B on W2 with W1 holding the other address
    wb = wr_d.size(); ob = out_d.size();
    send(6'd10, {8{32'd1}}, 1'b1, 1'b0, acc);
    send(6'd20, {8{32'd100}}, 1'b1, 1'b0, acc);
    send(6'd10, {8{32'd2}}, 1'b0, 1'b1, acc);
    send(6'd20, {8{32'd200}}, 1'b0, 1'b1, acc);
    cycles(6);
    poison = 1'b0;
    check("t3_nout", out_d.size() - ob, 2);
    check("t3_out_a_data", out_d[ob], {8{32'd3}});
    check("t3_out_a_addr", out_a[ob], 10);
    check("t3_out_b_data", out_d[ob+1], {8{32'd300}});
    check("t3_out_b_addr", out_a[ob+1], 20);

    // lane overflow and lane isolation
    for (int i = 0; i < 8; i++) begin
      va[i*32 +: 32] = 32'(i);
      vb[i*32 +: 32] = 32'd1;
      ve[i*32 +: 32] = 32'(i + 1);
    end
    va[31:0]  = 32'h7FFFFFFF;
    va[63:32] = 32'hFFFFFFFF;
    ve[63:32] = 32'h0;
    va[95:64] = 32'h80000000;
    vb[95:64] = 32'hFFFFFFFF;
`ifdef NVDLA_CACC_ABUF_SAT_EN
    ve[31:0]  = 32'h7FFFFFFF;
    ve[95:64] = 32'h80000000;
`else
    ve[31:0]  = 32'h80000000;
    ve[95:64] = 32'h7FFFFFFF;
`endif
    ob = out_d.size();
    send(6'd5, va, 1'b1, 1'b0, acc);
    send(6'd5, vb, 1'b0, 1'b1, acc);
    cycles(6);
    check("t4_nout", out_d.size() - ob, 1);
    check("t4_out_data", out_d[ob], ve);
`ifdef NVDLA_CACC_ABUF_SAT_EN
    check("t4_sat_flag", sat_flag, 1);
`endif

    // credits: refill (returns at full are ignored), drain, single return, concurrent
    return_all();
    check("t5_refill", dut.credit_cnt, 16);
    ob = out_d.size();
    n_acc = 0;
    for (int i = 0; i < 16; i++) begin
      send(6'(i), {8{32'(i)}}, 1'b1, 1'b1, acc);
      if (acc) n_acc++;
    end
    check("t5_n_accept", n_acc, 16);
    check("t5_ready_low", in_ready, 0);
    send(6'd30, {8{32'd9}}, 1'b1, 1'b1, acc);
    check("t5_blocked", acc, 0);
    dlv_credit_ret = 1'b1;
    cycles(1);
    dlv_credit_ret = 1'b0;
    check("t5_one_credit", dut.credit_cnt, 1);
    send(6'd31, {8{32'd9}}, 1'b1, 1'b1, acc);
    check("t5_one_accept", acc, 1);
    check("t5_ready_low2", in_ready, 0);
    dlv_credit_ret = 1'b1;
    cycles(1);
    send(6'd32, {8{32'd9}}, 1'b1, 1'b1, acc);
    dlv_credit_ret = 1'b0;
    check("t5_concurrent_acc", acc, 1);
    check("t5_concurrent_cnt", dut.credit_cnt, 1);
    cycles(6);
    check("t5_nout", out_d.size() - ob, 18);

    // reset with two ops in flight
    return_all();
    wb = wr_d.size(); ob = out_d.size();
    send(6'd1, {8{32'd1}}, 1'b1, 1'b0, acc);
    send(6'd2, {8{32'd2}}, 1'b1, 1'b1, acc);
    rstn = 1'b0;
    cycles(2);
    rstn = 1'b1;
    cycles(8);
    check("t6_no_wr", wr_d.size() - wb, 0);
    check("t6_no_out", out_d.size() - ob, 0);
    check("t6_credit", dut.credit_cnt, 16);
    check("t6_ready", in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
